result_arbiter: RTL and testbench
=================================

RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 Parameter RESULT_WIDTH, default 32, width of every result word.
REQ-002 Parameter DROP_CNT_WIDTH, default 16, width of the saturating drop counter.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-005 init  input  1  synchronous sequence restart; same clearing as reset while high.
REQ-006 dds_data  input  RESULT_WIDTH  DDS readback word; valid only while dds_wr high.
REQ-007 dds_wr  input  1  single-cycle DDS result strobe.
REQ-008 spi_data  input  RESULT_WIDTH  SPI readback word; valid only while spi_wr high.
REQ-009 spi_wr  input  1  single-cycle SPI result strobe.
REQ-010 loop_data  input  RESULT_WIDTH  loop-back word; valid only while loop_wr high.
REQ-011 loop_wr  input  1  single-cycle loop-back strobe.
REQ-012 result_fifo_full  input  1  downstream result FIFO full.
REQ-013 result_fifo_wr_data  output  RESULT_WIDTH  word written to result FIFO.
REQ-014 result_fifo_wr_en  output  1  write strobe; one word per high cycle.
REQ-015 overflow  output  1  sticky flag: at least one result dropped.
REQ-016 drop_count  output  DROP_CNT_WIDTH  saturating count of dropped results.
REQ-017 write_count  output  32  wrapping count of words written to the FIFO.
REQ-018 pending  output  1  high while any holding slot is occupied.

Function
REQ-019 Three one-entry holding slots, index 0=DDS, 1=SPI, 2=loop-back, each a valid bit plus data register.
REQ-020 Strobe high in cycle N: data captured into its slot at the end of cycle N; slot valid from cycle N+1.
REQ-021 result_fifo_wr_en = (any slot valid) AND NOT result_fifo_full, combinational; wr_data = granted slot data in the same cycle.
REQ-022 Minimum latency strobe-to-write: 1 cycle (wr_en in cycle N+1).
REQ-023 Grant: round-robin; search order starts at (last_grant+1) mod 3; last_grant updates only when wr_en high.
REQ-024 Granted slot is cleared at the end of the write cycle, unless its source strobes in that same cycle, in which case the new word is captured and the slot stays valid (no drop).
REQ-025 Strobe to an occupied slot not being drained that cycle: new word discarded, old word kept, overflow set, drop_count incremented.
REQ-026 Several sources dropping in one cycle: drop_count increases by the number of drops; saturates at all-ones, never wraps.
REQ-027 result_fifo_full high: no write, no slot cleared, last_grant unchanged; captures and drops proceed normally.
REQ-028 write_count increments by 1 per wr_en cycle, wraps at 2^32.
REQ-029 Sustained throughput: one word per cycle while FIFO not full; all three sources striking together drain in 3 consecutive cycles.
REQ-030 overflow clears only on reset or init.

Reset
REQ-031 On resetn low or init high: all slots invalid, last_grant=2 (DDS searched first), overflow=0, drop_count=0, write_count=0, wr_en=0, pending=0.
REQ-032 Strobes arriving while resetn low or init high are discarded and not counted as drops.
REQ-033 Reset mid-drain: held words are lost, no partial write issued; first strobe after release behaves as from idle.

Structure
REQ-034 Source index constants (SRC_DDS=0, SRC_SPI=1, SRC_LOOP=2) and N_RESULT_SRC=3 live in the shared pulse-controller package.
REQ-035 One sub-module, result_slot (valid/data register with capture, drain, and drop outputs), instantiated three times; arbitration and counters in the top level.

Verification
REQ-036 dds_wr with 0xDEADBEEF in cycle 10, FIFO not full -> wr_en high in cycle 11 only, wr_data 0xDEADBEEF, write_count=1.
REQ-037 dds/spi/loop strobes in the same cycle with 0x1/0x2/0x3 after reset -> writes 0x1, 0x2, 0x3 in three consecutive cycles; overflow=0.
REQ-038 FIFO full held; loop_wr 0xA then 0xB -> 0xA retained, overflow=1, drop_count=1; full released -> single write of 0xA.
REQ-039 Slot drained while same source strobes 0x55 -> old word written that cycle, 0x55 written later, drop_count unchanged.
REQ-040 DROP_CNT_WIDTH=4, 20 drops -> drop_count saturates at 15; init pulse -> drop_count=0, overflow=0, pending=0.
REQ-041 resetn asserted asynchronously while two slots valid -> wr_en low immediately, no writes after release until a new strobe.

Source files
------------

// File: rtl/result_arbiter_pkg.sv
// Shared constants and the round-robin helper for the result arbiter.
package result_arbiter_pkg;

    localparam int N_RESULT_SRC = 3;

    localparam logic [1:0] SRC_DDS  = 2'd0;
    localparam logic [1:0] SRC_SPI  = 2'd1;
    localparam logic [1:0] SRC_LOOP = 2'd2;

    function automatic logic [1:0] next_src(input logic [1:0] src);
        return (src == SRC_LOOP) ? SRC_DDS : src + 2'd1;
    endfunction

    // First valid slot at or after (last+1) mod 3; result is don't-care when nothing is valid.
    function automatic logic [1:0] rr_pick(input logic [N_RESULT_SRC-1:0] valid,
                                           input logic [1:0]              last);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = next_src(last);
        pick  = cand;
        found = 1'b0;
        for (int i = 0; i < N_RESULT_SRC; i++) begin
            if (!found && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_src(cand);
        end
        return pick;
    endfunction

endpackage

// File: rtl/result_arbiter_slot.sv
// One-entry holding slot: captures a strobed word when empty or being drained,
// otherwise reports the strobe as a drop and keeps the old word.
module result_slot
    import result_arbiter_pkg::*;
#(
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    init,
    input  logic                    strobe,
    input  logic [RESULT_WIDTH-1:0] strobe_data,
    input  logic                    drain,
    output logic                    valid,
    output logic [RESULT_WIDTH-1:0] data,
    output logic                    drop
);

    logic capture;

    always_comb begin
        capture = strobe && !init && (!valid || drain);
        drop    = strobe && !init && valid && !drain;
    end

    // NOTE: non-blocking assignments only in clocked blocks, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (init) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= strobe_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/result_arbiter.sv
// Merges DDS, SPI and loop-back results into one FIFO write port with
// round-robin grant, drop detection and write/drop statistics.
module result_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int RESULT_WIDTH   = 32,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      init,
    input  logic [RESULT_WIDTH-1:0]   dds_data,
    input  logic                      dds_wr,
    input  logic [RESULT_WIDTH-1:0]   spi_data,
    input  logic                      spi_wr,
    input  logic [RESULT_WIDTH-1:0]   loop_data,
    input  logic                      loop_wr,
    input  logic                      result_fifo_full,
    output logic [RESULT_WIDTH-1:0]   result_fifo_wr_data,
    output logic                      result_fifo_wr_en,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic [31:0]               write_count,
    output logic                      pending
);

    localparam int SUM_W = DROP_CNT_WIDTH + 1;

    logic [N_RESULT_SRC-1:0] strobe;
    logic [N_RESULT_SRC-1:0] slot_valid;
    logic [N_RESULT_SRC-1:0] slot_drop;
    logic [N_RESULT_SRC-1:0] drain;
    logic [RESULT_WIDTH-1:0] strobe_data [N_RESULT_SRC];
    logic [RESULT_WIDTH-1:0] slot_data   [N_RESULT_SRC];

    logic [1:0]                last_grant;
    logic [1:0]                grant;
    logic [1:0]                drops;
    logic [SUM_W-1:0]          drop_sum;
    logic [DROP_CNT_WIDTH-1:0] drop_next;

    always_comb begin
        strobe                   = {loop_wr, spi_wr, dds_wr};
        strobe_data[SRC_DDS]     = dds_data;
        strobe_data[SRC_SPI]     = spi_data;
        strobe_data[SRC_LOOP]    = loop_data;
    end

    for (genvar g = 0; g < N_RESULT_SRC; g++) begin : g_slot
        result_slot #(
            .RESULT_WIDTH (RESULT_WIDTH)
        ) u_slot (
            .clock       (clock),
            .resetn      (resetn),
            .init        (init),
            .strobe      (strobe[g]),
            .strobe_data (strobe_data[g]),
            .drain       (drain[g]),
            .valid       (slot_valid[g]),
            .data        (slot_data[g]),
            .drop        (slot_drop[g])
        );
    end

    // NOTE: every output of this block is assigned up front so no path leaves
    // a value held, which would otherwise infer a latch.
    always_comb begin
        grant               = rr_pick(slot_valid, last_grant);
        result_fifo_wr_en   = (|slot_valid) && !result_fifo_full && !init;
        result_fifo_wr_data = slot_data[grant];
        pending             = |slot_valid;
        for (int i = 0; i < N_RESULT_SRC; i++) begin
            drain[i] = result_fifo_wr_en && (grant == 2'(i));
        end
        drops     = 2'(slot_drop[0]) + 2'(slot_drop[1]) + 2'(slot_drop[2]);
        drop_sum  = {1'b0, drop_count} + SUM_W'(drops);
        drop_next = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    // last_grant resets to LOOP so that DDS is searched first.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant  <= SRC_LOOP;
            overflow    <= 1'b0;
            drop_count  <= '0;
            write_count <= '0;
        end else if (init) begin
            last_grant  <= SRC_LOOP;
            overflow    <= 1'b0;
            drop_count  <= '0;
            write_count <= '0;
        end else begin
            if (result_fifo_wr_en) begin
                last_grant  <= grant;
                write_count <= write_count + 32'd1;
            end
            if (|slot_drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_next;
            end
        end
    end

endmodule

// File: tb/tb_result_arbiter.sv
// Directed self-checking bench for result_arbiter: cycle table plus hand-written
// saturation, init and asynchronous-reset sequences.
module tb_result_arbiter;

    logic        clock;
    logic        resetn;
    logic        init;
    logic [31:0] dds_data, spi_data, loop_data;
    logic        dds_wr, spi_wr, loop_wr;
    logic        result_fifo_full;
    logic [31:0] result_fifo_wr_data;
    logic        result_fifo_wr_en;
    logic        overflow;
    logic [3:0]  drop_count;
    logic [31:0] write_count;
    logic        pending;

    int total = 0;
    int bad   = 0;

    result_arbiter #(
        .RESULT_WIDTH   (32),
        .DROP_CNT_WIDTH (4)
    ) dut (
        .clock               (clock),
        .resetn              (resetn),
        .init                (init),
        .dds_data            (dds_data),
        .dds_wr              (dds_wr),
        .spi_data            (spi_data),
        .spi_wr              (spi_wr),
        .loop_data           (loop_data),
        .loop_wr             (loop_wr),
        .result_fifo_full    (result_fifo_full),
        .result_fifo_wr_data (result_fifo_wr_data),
        .result_fifo_wr_en   (result_fifo_wr_en),
        .overflow            (overflow),
        .drop_count          (drop_count),
        .write_count         (write_count),
        .pending             (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        dw;
        logic [31:0] dd;
        logic        sw;
        logic [31:0] sd;
        logic        lw;
        logic [31:0] ld;
        logic        full;
        logic        in;
        logic        e_wr;
        logic [31:0] e_data;
        logic        e_ovf;
        logic [3:0]  e_dc;
        logic        e_pend;
        logic [31:0] e_wc;
    } vec_t;

    localparam int N_VEC = 25;
    vec_t tbl [N_VEC];

    function automatic vec_t mk(input logic dw, input logic [31:0] dd,
                                input logic sw, input logic [31:0] sd,
                                input logic lw, input logic [31:0] ld,
                                input logic full, input logic in,
                                input logic e_wr, input logic [31:0] e_data,
                                input logic e_ovf, input logic [3:0] e_dc,
                                input logic e_pend, input logic [31:0] e_wc);
        vec_t v;
        v.dw = dw; v.dd = dd; v.sw = sw; v.sd = sd; v.lw = lw; v.ld = ld;
        v.full = full; v.in = in;
        v.e_wr = e_wr; v.e_data = e_data; v.e_ovf = e_ovf; v.e_dc = e_dc;
        v.e_pend = e_pend; v.e_wc = e_wc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic dw, input logic [31:0] dd,
                         input logic sw, input logic [31:0] sd,
                         input logic lw, input logic [31:0] ld,
                         input logic full, input logic in);
        dds_wr = dw; dds_data = dd;
        spi_wr = sw; spi_data = sd;
        loop_wr = lw; loop_data = ld;
        result_fifo_full = full;
        init = in;
    endtask

    task automatic idle(input logic full);
        apply(0, 0, 0, 0, 0, 0, full, 0);
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Cycle table: inputs for one cycle and the outputs expected in it.
        tbl[0]  = mk(0,0, 0,0, 0,0, 0,0,  0,0,            0,0, 0,0);
        tbl[1]  = mk(1,1, 1,2, 1,3, 0,0,  0,0,            0,0, 0,0);
        tbl[2]  = mk(0,0, 0,0, 0,0, 0,0,  1,1,            0,0, 1,0);
        tbl[3]  = mk(0,0, 0,0, 0,0, 0,0,  1,2,            0,0, 1,1);
        tbl[4]  = mk(0,0, 0,0, 0,0, 0,0,  1,3,            0,0, 1,2);
        tbl[5]  = mk(0,0, 0,0, 0,0, 0,0,  0,0,            0,0, 0,3);
        tbl[6]  = mk(1,32'hDEADBEEF, 0,0, 0,0, 0,0, 0,0, 0,0, 0,3);
        tbl[7]  = mk(0,0, 0,0, 0,0, 0,0,  1,32'hDEADBEEF, 0,0, 1,3);
        tbl[8]  = mk(0,0, 0,0, 0,0, 0,0,  0,0,            0,0, 0,4);
        tbl[9]  = mk(0,0, 0,0, 1,32'hA, 1,0, 0,0,         0,0, 0,4);
        tbl[10] = mk(0,0, 0,0, 1,32'hB, 1,0, 0,0,         0,0, 1,4);
        tbl[11] = mk(0,0, 0,0, 0,0, 1,0,  0,0,            1,1, 1,4);
        tbl[12] = mk(0,0, 0,0, 0,0, 0,0,  1,32'hA,        1,1, 1,4);
        tbl[13] = mk(0,0, 0,0, 0,0, 0,0,  0,0,            1,1, 0,5);
        tbl[14] = mk(0,0, 1,32'h44, 0,0, 0,0, 0,0,        1,1, 0,5);
        tbl[15] = mk(0,0, 1,32'h55, 0,0, 0,0, 1,32'h44,   1,1, 1,5);
        tbl[16] = mk(0,0, 0,0, 0,0, 0,0,  1,32'h55,       1,1, 1,6);
        tbl[17] = mk(0,0, 0,0, 0,0, 0,0,  0,0,            1,1, 0,7);
        tbl[18] = mk(1,32'h10, 1,32'h20, 0,0, 0,0, 0,0,   1,1, 0,7);
        tbl[19] = mk(1,32'h11, 0,0, 0,0, 0,0, 1,32'h10,   1,1, 1,7);
        tbl[20] = mk(0,0, 0,0, 0,0, 0,0,  1,32'h20,       1,1, 1,8);
        tbl[21] = mk(0,0, 0,0, 0,0, 0,0,  1,32'h11,       1,1, 1,9);
        tbl[22] = mk(0,0, 0,0, 0,0, 0,0,  0,0,            1,1, 0,10);
        tbl[23] = mk(1,32'h99, 0,0, 0,0, 0,1, 0,0,        1,1, 0,10);
        tbl[24] = mk(0,0, 0,0, 0,0, 0,0,  0,0,            0,0, 0,0);

        // Reset state, with a strobe present while reset is held.
        resetn = 1'b0;
        apply(1, 32'h1234, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst wr_en", 32'(result_fifo_wr_en), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst drop_count", 32'(drop_count), 0);
        check("rst write_count", write_count, 0);
        check("rst pending", 32'(pending), 0);
        next_cycle();
        idle(0);
        #2 resetn = 1'b1;
        @(negedge clock);
        check("rst strobe discarded", 32'(pending), 0);
        next_cycle();

        for (int i = 0; i < N_VEC; i++) begin
            apply(tbl[i].dw, tbl[i].dd, tbl[i].sw, tbl[i].sd,
                  tbl[i].lw, tbl[i].ld, tbl[i].full, tbl[i].in);
            @(negedge clock);
            check($sformatf("row%0d wr_en", i), 32'(result_fifo_wr_en), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr)
                check($sformatf("row%0d wr_data", i), result_fifo_wr_data, tbl[i].e_data);
            check($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
            check($sformatf("row%0d drop_count", i), 32'(drop_count), 32'(tbl[i].e_dc));
            check($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
            check($sformatf("row%0d write_count", i), write_count, tbl[i].e_wc);
            next_cycle();
        end

        // Drop counter saturation with the FIFO held full.
        apply(1, 1, 1, 2, 1, 3, 1, 0);
        next_cycle();
        for (int k = 1; k <= 7; k++) begin
            apply(1, 32'h100, 1, 32'h200, 1, 32'h300, 1, 0);
            @(negedge clock);
            if (k == 5) check("sat after 12 drops", 32'(drop_count), 12);
            if (k == 6) check("sat after 15 drops", 32'(drop_count), 15);
            next_cycle();
        end
        idle(1);
        @(negedge clock);
        check("sat after 21 drops", 32'(drop_count), 15);
        check("sat overflow", 32'(overflow), 1);
        check("sat pending", 32'(pending), 1);
        next_cycle();
        apply(0, 0, 0, 0, 0, 0, 1, 1);
        next_cycle();
        idle(0);
        @(negedge clock);
        check("init drop_count", 32'(drop_count), 0);
        check("init overflow", 32'(overflow), 0);
        check("init pending", 32'(pending), 0);
        check("init wr_en", 32'(result_fifo_wr_en), 0);
        check("init write_count", write_count, 0);
        next_cycle();

        // Asynchronous reset mid-drain with two slots valid.
        apply(1, 32'hA1, 1, 32'hA2, 0, 0, 0, 0);
        next_cycle();
        idle(0);
        @(negedge clock);
        check("drain wr_en", 32'(result_fifo_wr_en), 1);
        check("drain wr_data", result_fifo_wr_data, 32'hA1);
        #2 resetn = 1'b0;
        #1;
        check("async rst wr_en", 32'(result_fifo_wr_en), 0);
        check("async rst pending", 32'(pending), 0);
        check("async rst write_count", write_count, 0);
        apply(0, 0, 0, 0, 1, 32'hBAD, 0, 0);
        next_cycle();
        idle(0);
        #2 resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("post rst idle%0d wr_en", k), 32'(result_fifo_wr_en), 0);
            check($sformatf("post rst idle%0d pending", k), 32'(pending), 0);
            next_cycle();
        end
        apply(0, 0, 0, 0, 1, 32'h77, 0, 0);
        @(negedge clock);
        check("post rst strobe wr_en", 32'(result_fifo_wr_en), 0);
        next_cycle();
        idle(0);
        @(negedge clock);
        check("post rst write wr_en", 32'(result_fifo_wr_en), 1);
        check("post rst write data", result_fifo_wr_data, 32'h77);
        next_cycle();
        @(negedge clock);
        check("post rst write_count", write_count, 1);
        check("post rst pending", 32'(pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
